// File: rtl/apb_mmu_pkg.sv
// Shared types and register map for the APB MMU configuration block.
// Offsets are relative to the 4 KiB APB window.
package apb_mmu_pkg;

    localparam logic [11:0] CTRL_OFS        = 12'h000;
    localparam logic [11:0] STATUS_OFS      = 12'h004;
    localparam logic [11:0] BOOT_ADDR_OFS   = 12'h100;
    localparam logic [11:0] REGION_BASE_OFS = 12'h200;
    localparam int          REGION_STRIDE   = 16;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CFG_VALID_BIT = 0;

    typedef enum logic [1:0] {
        FLD_BASE  = 2'd0,
        FLD_MASK  = 2'd1,
        FLD_TRANS = 2'd2,
        FLD_CFG   = 2'd3
    } region_fld_e;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
        logic [31:0] trans;
        logic        valid;
    } region_t;

endpackage

// File: rtl/apb_mmu_xlate.sv
// Combinational priority remapper: the lowest-numbered
// enabled region that matches the address wins.
module apb_mmu_xlate
    import apb_mmu_pkg::*;
#(
    parameter int N_REGIONS = 4
) (
    input  region_t [N_REGIONS-1:0] regions,
    input  logic                    en,
    input  logic [31:0]             core_addr_i,
    output logic [31:0]             core_addr_o,
    output logic                    hit_o
);

    always_comb begin
        core_addr_o = core_addr_i;
        hit_o       = 1'b0;
        // Walk downwards so the lowest index is assigned last.
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (en && regions[i].valid &&
                ((core_addr_i & regions[i].mask) ==
                 (regions[i].base & regions[i].mask))) begin
                core_addr_o = (regions[i].trans & regions[i].mask)
                            | (core_addr_i & ~regions[i].mask);
                hit_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_mmu_ctrl.sv
// APB3 slave holding boot address, MMU enable and remap regions;
// drives the combinational address translator.
module apb_mmu_ctrl
    import apb_mmu_pkg::*;
#(
    parameter int          N_REGIONS     = 4,
    parameter logic [31:0] BASE_ADDR     = 32'h1A10_3000,
    parameter logic [31:0] BOOT_ADDR_RST = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PSEL,
    input  logic        PENABLE,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] boot_addr_o,
    output logic        mmu_en_o,
    input  logic [31:0] core_addr_i,
    output logic [31:0] core_addr_o,
    output logic        hit_o
);

    localparam logic [3:0] NR = 4'(N_REGIONS);

    logic                    ctrl_en;
    logic [31:0]             boot_addr;
    region_t [N_REGIONS-1:0] regions;

    logic [11:0] ofs;
    logic [3:0]  idx;
    region_fld_e fld;
    logic        in_win;
    logic        aligned;
    logic        is_ctrl;
    logic        is_stat;
    logic        is_boot;
    logic        is_reg;
    logic        mapped;
    logic        err;
    logic        wr;
    logic [31:0] rdata;

    assign ofs     = PADDR[11:0];
    assign idx     = ofs[7:4];
    assign fld     = region_fld_e'(ofs[3:2]);
    assign in_win  = (PADDR[31:12] == BASE_ADDR[31:12]);
    assign aligned = (PADDR[1:0] == 2'b00);
    assign is_ctrl = (ofs == CTRL_OFS);
    assign is_stat = (ofs == STATUS_OFS);
    assign is_boot = (ofs == BOOT_ADDR_OFS);
    assign is_reg  = (ofs[11:8] == REGION_BASE_OFS[11:8]) && (idx < NR);
    assign mapped  = is_ctrl | is_stat | is_boot | is_reg;
    assign err     = !in_win | !aligned | !mapped;

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & err;
    assign PRDATA  = (PSEL && !err) ? rdata : 32'h0;
    assign wr      = PSEL & PENABLE & PWRITE & !err;

    always_comb begin
        rdata = 32'h0;
        unique case (1'b1)
            is_ctrl: rdata[CTRL_EN_BIT] = ctrl_en;
            is_stat: rdata[3:0] = NR;
            is_boot: rdata = boot_addr;
            is_reg: begin
                for (int i = 0; i < N_REGIONS; i++) begin
                    if (idx == 4'(i)) begin
                        unique case (fld)
                            FLD_BASE:  rdata = regions[i].base;
                            FLD_MASK:  rdata = regions[i].mask;
                            FLD_TRANS: rdata = regions[i].trans;
                            FLD_CFG:   rdata[CFG_VALID_BIT] =
                                           regions[i].valid;
                        endcase
                    end
                end
            end
            default: rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_en   <= 1'b0;
            boot_addr <= BOOT_ADDR_RST;
            for (int i = 0; i < N_REGIONS; i++) begin
                regions[i] <= '0;
            end
        end else if (wr) begin
            if (is_ctrl) ctrl_en <= PWDATA[CTRL_EN_BIT];
            if (is_boot) boot_addr <= PWDATA;
            for (int i = 0; i < N_REGIONS; i++) begin
                if (is_reg && idx == 4'(i)) begin
                    unique case (fld)
                        FLD_BASE:  regions[i].base  <= PWDATA;
                        FLD_MASK:  regions[i].mask  <= PWDATA;
                        FLD_TRANS: regions[i].trans <= PWDATA;
                        FLD_CFG:   regions[i].valid <=
                                       PWDATA[CFG_VALID_BIT];
                    endcase
                end
            end
        end
    end

    assign boot_addr_o = boot_addr;
    assign mmu_en_o    = ctrl_en;

    apb_mmu_xlate #(
        .N_REGIONS (N_REGIONS)
    ) u_xlate (
        .regions     (regions),
        .en          (ctrl_en),
        .core_addr_i (core_addr_i),
        .core_addr_o (core_addr_o),
        .hit_o       (hit_o)
    );

endmodule

// File: tb/tb_apb_mmu_ctrl.sv
// Directed bench for apb_mmu_ctrl: register access, errors,
// translation priority and reset during a transfer.
module tb_apb_mmu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] boot_addr_o;
    logic        mmu_en_o;
    logic [31:0] core_addr_i;
    logic [31:0] core_addr_o;
    logic        hit_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] B = 32'h1A10_3000;

    always #5 clk = ~clk;

    apb_mmu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .boot_addr_o (boot_addr_o),
        .mmu_en_o    (mmu_en_o),
        .core_addr_i (core_addr_i),
        .core_addr_o (core_addr_o),
        .hit_o       (hit_o)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One SETUP+ACCESS transfer; outputs sampled mid ACCESS.
    task automatic apb(input logic wr,
                       input logic [31:0] addr,
                       input logic [31:0] data,
                       output logic [31:0] rd,
                       output logic err,
                       output logic rdy);
        @(posedge clk); #1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        #3;
        rd  = PRDATA;
        err = PSLVERR;
        rdy = PREADY;
        @(posedge clk); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    logic        rdy;

    task automatic wr_ok(input logic [31:0] addr,
                         input logic [31:0] data);
        apb(1'b1, addr, data, rd, err, rdy);
        chk("wr_err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        PADDR       = '0;
        PWDATA      = '0;
        PWRITE      = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        core_addr_i = 32'h0010_1234;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #3;

        chk("rst_boot", boot_addr_o, 32'h0000_8000);
        chk("rst_en", {31'd0, mmu_en_o}, 32'd0);
        chk("rst_hit", {31'd0, hit_o}, 32'd0);
        chk("rst_xlate", core_addr_o, 32'h0010_1234);
        chk("idle_err", {31'd0, PSLVERR}, 32'd0);
        chk("idle_rdata", PRDATA, 32'd0);

        apb(1'b0, B + 32'h100, 32'd0, rd, err, rdy);
        chk("rd_boot", rd, 32'h0000_8000);
        chk("rd_boot_err", {31'd0, err}, 32'd0);
        chk("rd_boot_rdy", {31'd0, rdy}, 32'd1);

        apb(1'b0, B + 32'h004, 32'd0, rd, err, rdy);
        chk("rd_status", rd, 32'd4);

        // Write BOOT_ADDR by hand to watch SETUP vs ACCESS.
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = B + 32'h100; PWDATA = 32'hFACE_DEAD;
        @(posedge clk); #1;
        chk("setup_nochg", boot_addr_o, 32'h0000_8000);
        PENABLE = 1'b1;
        #3;
        chk("access_nochg", boot_addr_o, 32'h0000_8000);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("commit_boot", boot_addr_o, 32'hFACE_DEAD);
        apb(1'b0, B + 32'h100, 32'd0, rd, err, rdy);
        chk("rd_boot2", rd, 32'hFACE_DEAD);

        apb(1'b1, B + 32'hFFC, 32'h1111_1111, rd, err, rdy);
        chk("err_unmap", {31'd0, err}, 32'd1);
        apb(1'b1, B + 32'h102, 32'h2222_2222, rd, err, rdy);
        chk("err_align", {31'd0, err}, 32'd1);
        apb(1'b1, 32'h1A10_4100, 32'h3333_3333, rd, err, rdy);
        chk("err_window", {31'd0, err}, 32'd1);
        apb(1'b1, B + 32'h240, 32'h4444_4444, rd, err, rdy);
        chk("err_region4", {31'd0, err}, 32'd1);
        apb(1'b0, B + 32'hFFC, 32'd0, rd, err, rdy);
        chk("err_rdata", rd, 32'd0);
        apb(1'b1, B + 32'h004, 32'h5555_5555, rd, err, rdy);
        chk("status_wr_err", {31'd0, err}, 32'd0);
        apb(1'b0, B + 32'h100, 32'd0, rd, err, rdy);
        chk("boot_kept", rd, 32'hFACE_DEAD);

        wr_ok(B + 32'h200, 32'h0010_0000);
        wr_ok(B + 32'h204, 32'hFFFF_0000);
        wr_ok(B + 32'h208, 32'h2000_0000);
        wr_ok(B + 32'h20C, 32'h0000_0001);
        chk("pre_en_hit", {31'd0, hit_o}, 32'd0);
        wr_ok(B + 32'h000, 32'h0000_0001);
        chk("en_out", {31'd0, mmu_en_o}, 32'd1);
        chk("r0_xlate", core_addr_o, 32'h2000_1234);
        chk("r0_hit", {31'd0, hit_o}, 32'd1);
        apb(1'b0, B + 32'h208, 32'd0, rd, err, rdy);
        chk("rd_trans0", rd, 32'h2000_0000);
        apb(1'b0, B + 32'h000, 32'd0, rd, err, rdy);
        chk("rd_ctrl", rd, 32'd1);

        core_addr_i = 32'h0011_1234;
        #1;
        chk("miss_xlate", core_addr_o, 32'h0011_1234);
        chk("miss_hit", {31'd0, hit_o}, 32'd0);
        core_addr_i = 32'h0010_1234;

        wr_ok(B + 32'h000, 32'h0000_0000);
        chk("dis_xlate", core_addr_o, 32'h0010_1234);
        chk("dis_hit", {31'd0, hit_o}, 32'd0);

        wr_ok(B + 32'h210, 32'h0010_0000);
        wr_ok(B + 32'h214, 32'hFFFF_0000);
        wr_ok(B + 32'h218, 32'h3000_0000);
        wr_ok(B + 32'h21C, 32'h0000_0001);
        wr_ok(B + 32'h000, 32'h0000_0001);
        chk("prio_xlate", core_addr_o, 32'h2000_1234);
        wr_ok(B + 32'h20C, 32'h0000_0000);
        chk("r1_xlate", core_addr_o, 32'h3000_1234);
        chk("r1_hit", {31'd0, hit_o}, 32'd1);

        // Reset lands on the ACCESS edge of a pending write.
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = B + 32'h100; PWDATA = 32'h1234_5678;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0;
        apb(1'b0, B + 32'h100, 32'd0, rd, err, rdy);
        chk("rst_mid_boot", rd, 32'h0000_8000);
        chk("rst_mid_hit", {31'd0, hit_o}, 32'd0);
        chk("rst_mid_xlate", core_addr_o, 32'h0010_1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
